turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/ttt_pkg.sv | 13 +
 rtl/turn_controller_if.sv | 23 ++
 rtl/turn_controller_win_check.sv | 14 +
 rtl/turn_controller.sv | 92 +++++++++
 tb/tb_turn_controller.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and constants for the tic-tac-toe turn controller
// NUM_CELLS  : number of board cells (cell i is bit i of a board vector)
// WIN_LINES  : the 8 winning cell masks (rows, columns, diagonals)
// state_t    : turn controller FSM states
package ttt_pkg;
  localparam int NUM_CELLS = 9;
  localparam logic [7:0][NUM_CELLS-1:0] WIN_LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };
  typedef enum logic [1:0] {P1_TURN, P2_TURN, CHECK, GAME_OVER} state_t;
endpackage

// File: rtl/turn_controller_if.sv
// turn_controller_if: move handshake, board and result signals of the turn controller
// master : player/host side (drives new_game and move requests)
// slave  : controller side (drives acks, reject, boards, turn, count and result flags)
interface turn_controller_if import ttt_pkg::*;;
  logic                 new_game;
  logic                 p1_move_valid, p2_move_valid;
  logic [3:0]           p1_move_cell, p2_move_cell;
  logic                 p1_move_ack, p2_move_ack, move_reject;
  logic [NUM_CELLS-1:0] board_p1, board_p2;
  logic                 turn;
  logic [3:0]           move_count;
  logic                 player1_win, player2_win, draw, game_over;
  modport master (
    output new_game, p1_move_valid, p2_move_valid, p1_move_cell, p2_move_cell,
    input  p1_move_ack, p2_move_ack, move_reject, board_p1, board_p2, turn,
           move_count, player1_win, player2_win, draw, game_over
  );
  modport slave (
    input  new_game, p1_move_valid, p2_move_valid, p1_move_cell, p2_move_cell,
    output p1_move_ack, p2_move_ack, move_reject, board_p1, board_p2, turn,
           move_count, player1_win, player2_win, draw, game_over
  );
endinterface

// File: rtl/turn_controller_win_check.sv
// win_check: combinational detector, win=1 when the board covers any of the 8 win lines
// board : one player's 9-bit cell occupancy
// win   : 1 if a full row, column or diagonal is occupied
module win_check
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  output logic                 win
);
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) win = win | ((board & WIN_LINES[i]) == WIN_LINES[i]);
  end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: tic-tac-toe move arbiter, board keeper and result detector
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : slave side of turn_controller_if (moves in; acks, reject, boards, turn, count, flags out)
module turn_controller
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input logic              clk,
  input logic              reset,
  turn_controller_if.slave bus
);
  localparam state_t START = FIRST_PLAYER ? P2_TURN : P1_TURN;
  state_t               state;
  logic                 cur_valid, cur_ok, win;
  logic [3:0]           cur_cell;
  logic [NUM_CELLS-1:0] cur_mask;
  // turn always matches the active turn state, and names the mover during CHECK
  always_comb begin
    cur_valid = bus.turn ? bus.p2_move_valid : bus.p1_move_valid;
    cur_cell  = bus.turn ? bus.p2_move_cell : bus.p1_move_cell;
    cur_mask  = NUM_CELLS'(1) << cur_cell;
    cur_ok    = (cur_cell < 4'(NUM_CELLS)) && !(|(cur_mask & (bus.board_p1 | bus.board_p2)));
  end
  win_check u_win_check (
    .board(bus.turn ? bus.board_p2 : bus.board_p1),
    .win  (win)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= START;
      bus.turn        <= FIRST_PLAYER;
      bus.board_p1    <= '0;
      bus.board_p2    <= '0;
      bus.move_count  <= '0;
      bus.p1_move_ack <= 1'b0;
      bus.p2_move_ack <= 1'b0;
      bus.move_reject <= 1'b0;
      bus.player1_win <= 1'b0;
      bus.player2_win <= 1'b0;
      bus.draw        <= 1'b0;
      bus.game_over   <= 1'b0;
    end else begin
      bus.p1_move_ack <= 1'b0;
      bus.p2_move_ack <= 1'b0;
      bus.move_reject <= 1'b0;
      if (bus.new_game) begin
        state           <= START;
        bus.turn        <= FIRST_PLAYER;
        bus.board_p1    <= '0;
        bus.board_p2    <= '0;
        bus.move_count  <= '0;
        bus.player1_win <= 1'b0;
        bus.player2_win <= 1'b0;
        bus.draw        <= 1'b0;
        bus.game_over   <= 1'b0;
      end else begin
        unique case (state)
          P1_TURN, P2_TURN: begin
            if (cur_valid && cur_ok) begin
              if (bus.turn) bus.board_p2 <= bus.board_p2 | cur_mask;
              else bus.board_p1 <= bus.board_p1 | cur_mask;
              bus.p1_move_ack <= !bus.turn;
              bus.p2_move_ack <= bus.turn;
              bus.move_count  <= bus.move_count + 4'd1;
              state           <= CHECK;
            end else if (cur_valid) begin
              bus.move_reject <= 1'b1;
            end
          end
          CHECK: begin
            if (win) begin
              bus.player1_win <= !bus.turn;
              bus.player2_win <= bus.turn;
              bus.game_over   <= 1'b1;
              state           <= GAME_OVER;
            end else if (bus.move_count == 4'(NUM_CELLS)) begin
              bus.draw      <= 1'b1;
              bus.game_over <= 1'b1;
              state         <= GAME_OVER;
            end else begin
              bus.turn <= !bus.turn;
              state    <= bus.turn ? P1_TURN : P2_TURN;
            end
          end
          GAME_OVER: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed self-checking bench for turn_controller (FIRST_PLAYER=0 and =1)
module tb_turn_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  turn_controller_if if0 ();
  turn_controller_if if1 ();
  turn_controller #(.FIRST_PLAYER(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  turn_controller #(.FIRST_PLAYER(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mv(input bit d, input bit p, input logic [3:0] c);
    @(negedge clk);
    if (d) begin
      if1.p1_move_valid = !p; if1.p2_move_valid = p; if1.p1_move_cell = c; if1.p2_move_cell = c;
    end else begin
      if0.p1_move_valid = !p; if0.p2_move_valid = p; if0.p1_move_cell = c; if0.p2_move_cell = c;
    end
    @(negedge clk);
    if1.p1_move_valid = 1'b0; if1.p2_move_valid = 1'b0;
    if0.p1_move_valid = 1'b0; if0.p2_move_valid = 1'b0;
  endtask
  task automatic play(input bit d, input bit p, input logic [3:0] c);
    mv(d, p, c);
    @(negedge clk);
  endtask
  task automatic ng(input bit d);
    @(negedge clk);
    if (d) if1.new_game = 1'b1; else if0.new_game = 1'b1;
    @(negedge clk);
    if1.new_game = 1'b0; if0.new_game = 1'b0;
  endtask
  task automatic chk_flags0(input string tag, input logic [3:0] exp);
    chk(tag, {if0.player1_win, if0.player2_win, if0.draw, if0.game_over}, exp);
  endtask
  initial begin
    if0.new_game = 0; if0.p1_move_valid = 0; if0.p2_move_valid = 0; if0.p1_move_cell = 0; if0.p2_move_cell = 0;
    if1.new_game = 0; if1.p1_move_valid = 0; if1.p2_move_valid = 0; if1.p1_move_cell = 0; if1.p2_move_cell = 0;
    #12;
    chk("rst_boards", {if0.board_p1, if0.board_p2}, 0);
    chk("rst_count", if0.move_count, 0);
    chk("rst_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 0);
    chk_flags0("rst_flags", 4'b0000);
    chk("rst_turn0", if0.turn, 0);
    chk("rst_turn1", if1.turn, 1);
    @(negedge clk); reset = 1'b1;
    // row win for player1
    play(0, 0, 0); play(0, 1, 3); play(0, 0, 1); play(0, 1, 4);
    mv(0, 0, 2);
    chk("row_ack", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b100);
    chk("row_flags_pending", if0.game_over, 0);
    @(negedge clk);
    chk_flags0("row_flags", 4'b1001);
    chk("row_count", if0.move_count, 5);
    chk("row_boards", {if0.board_p1, if0.board_p2}, {9'h007, 9'h018});
    // game over lock
    play(0, 1, 5); play(0, 0, 6);
    chk("lock_boards", {if0.board_p1, if0.board_p2}, {9'h007, 9'h018});
    chk("lock_count", if0.move_count, 5);
    chk_flags0("lock_flags", 4'b1001);
    // new_game beats a simultaneous move
    @(negedge clk);
    if0.new_game = 1'b1; if0.p1_move_valid = 1'b1; if0.p1_move_cell = 4'd8;
    @(negedge clk);
    if0.new_game = 1'b0; if0.p1_move_valid = 1'b0;
    chk("ng_boards", {if0.board_p1, if0.board_p2}, 0);
    chk("ng_count", if0.move_count, 0);
    chk("ng_ack", if0.p1_move_ack, 0);
    chk_flags0("ng_flags", 4'b0000);
    chk("ng_turn", if0.turn, 0);
    // occupied cell
    play(0, 0, 4);
    mv(0, 1, 4);
    chk("occ_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b001);
    chk("occ_turn", if0.turn, 1);
    chk("occ_board_p2", if0.board_p2, 0);
    @(negedge clk);
    chk("occ_reject_pulse", if0.move_reject, 0);
    mv(0, 1, 5);
    chk("occ_retry_ack", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b010);
    @(negedge clk);
    chk("occ_turn_back", if0.turn, 0);
    // bad index, off-turn, simultaneous
    mv(0, 0, 9);
    chk("idx_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b001);
    chk("idx_board", if0.board_p1, 9'h010);
    mv(0, 1, 7);
    chk("off_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b000);
    chk("off_board", if0.board_p2, 9'h020);
    @(negedge clk);
    if0.p1_move_valid = 1'b1; if0.p1_move_cell = 4'd0; if0.p2_move_valid = 1'b1; if0.p2_move_cell = 4'd1;
    @(negedge clk);
    if0.p1_move_valid = 1'b0; if0.p2_move_valid = 1'b0;
    chk("both_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 3'b100);
    chk("both_boards", {if0.board_p1, if0.board_p2}, {9'h011, 9'h020});
    @(negedge clk);
    chk("both_turn", if0.turn, 1);
    chk("both_count", if0.move_count, 3);
    // draw
    ng(0);
    play(0, 0, 0); play(0, 1, 1); play(0, 0, 2); play(0, 1, 4); play(0, 0, 3);
    play(0, 1, 6); play(0, 0, 7); play(0, 1, 8); play(0, 0, 5);
    chk_flags0("draw_flags", 4'b0011);
    chk("draw_count", if0.move_count, 9);
    chk("draw_boards", {if0.board_p1, if0.board_p2}, {9'h0AD, 9'h152});
    // win on the ninth move
    ng(0);
    play(0, 0, 1); play(0, 1, 4); play(0, 0, 2); play(0, 1, 5); play(0, 0, 3);
    play(0, 1, 6); play(0, 0, 7); play(0, 1, 8); play(0, 0, 0);
    chk_flags0("win9_flags", 4'b1001);
    chk("win9_count", if0.move_count, 9);
    chk("win9_board_p1", if0.board_p1, 9'h08F);
    // FIRST_PLAYER=1: player2 wins, then restart
    play(1, 1, 0); play(1, 0, 3); play(1, 1, 1); play(1, 0, 4); play(1, 1, 2);
    chk("fp1_flags", {if1.player1_win, if1.player2_win, if1.draw, if1.game_over}, 4'b0101);
    chk("fp1_boards", {if1.board_p1, if1.board_p2}, {9'h018, 9'h007});
    ng(1);
    chk("fp1_ng_boards", {if1.board_p1, if1.board_p2}, 0);
    chk("fp1_ng_turn", if1.turn, 1);
    chk("fp1_ng_flags", {if1.player1_win, if1.player2_win, if1.draw, if1.game_over, if1.move_count}, 0);
    // reset during CHECK
    ng(0);
    mv(0, 0, 4);
    chk("rc_accepted", if0.board_p1, 9'h010);
    reset = 1'b0;
    #1;
    chk("rc_boards", {if0.board_p1, if0.board_p2}, 0);
    chk("rc_count", if0.move_count, 0);
    chk("rc_pulses", {if0.p1_move_ack, if0.p2_move_ack, if0.move_reject}, 0);
    chk("rc_turns", {if0.turn, if1.turn}, 2'b01);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rc_after_board", if0.board_p1, 0);
    chk("rc_after_turn", if0.turn, 0);
    mv(0, 0, 4);
    chk("rc_replay_ack", if0.p1_move_ack, 1);
    chk("rc_replay_count", if0.move_count, 1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
